// File: rtl/dma_pkg.sv
// Shared DMA definitions: channel-index width helper and arbiter state encoding.
package dma_pkg;

  typedef enum logic {
    ArbIdle,
    ArbBusy
  } arb_state_e;

  // Ceiling log2; returns 0 for n <= 1 so a single channel still gets a 1-bit index.
  function automatic int unsigned C_LOG_2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-side round-robin arbiter: IDLE/BUSY FSM holding one registered grant until done.
module rr_arbiter
  import dma_pkg::*;
#(
  parameter int unsigned NumCh = 4,
  parameter int unsigned ChW   = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumCh-1:0] req_i,
  input  logic             done_i,
  output logic [ChW-1:0]   active_ch_o,
  output logic             grant_valid_o
);

  localparam logic [ChW-1:0] LastReset = ChW'(NumCh - 1);

  arb_state_e     state_q, state_d;
  logic [ChW-1:0] ch_q, ch_d;
  logic [ChW-1:0] last_q, last_d;
  logic [ChW-1:0] winner;
  logic           found;

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    int idx;
    idx    = 0;
    winner = last_q;
    found  = 1'b0;
    for (int i = 1; i <= int'(NumCh); i++) begin
      idx = (int'(last_q) + i) % int'(NumCh);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = ChW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    unique case (state_q)
      ArbIdle: begin
        if (found) begin
          ch_d    = winner;
          state_d = ArbBusy;
        end
      end
      ArbBusy: begin
        if (done_i) begin
          last_d  = ch_q;
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ArbIdle;
      ch_q    <= '0;
      last_q  <= LastReset;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
    end
  end

  assign active_ch_o   = ch_q;
  assign grant_valid_o = (state_q == ArbBusy);

endmodule

// File: rtl/channel_arbiter.sv
// DMA channel arbiter: independent round-robin grants for the read (fill) and write (drain) sides.
module channel_arbiter
  import dma_pkg::*;
#(
  parameter int unsigned C_M_NUM_CHANNELS = 4,
  parameter int unsigned CH_W             = C_LOG_2(C_M_NUM_CHANNELS) + 1
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESETN,
  input  logic [C_M_NUM_CHANNELS-1:0] r_req,
  input  logic                        r_done,
  input  logic [C_M_NUM_CHANNELS-1:0] w_req,
  input  logic                        w_done,
  output logic [CH_W-1:0]             r_active_channel,
  output logic                        r_grant_valid,
  output logic [CH_W-1:0]             w_active_channel,
  output logic                        w_grant_valid
);

  rr_arbiter #(
    .NumCh (C_M_NUM_CHANNELS),
    .ChW   (CH_W)
  ) u_rd_arb (
    .clk_i         (M_AXI_ACLK),
    .rst_ni        (M_AXI_ARESETN),
    .req_i         (r_req),
    .done_i        (r_done),
    .active_ch_o   (r_active_channel),
    .grant_valid_o (r_grant_valid)
  );

  rr_arbiter #(
    .NumCh (C_M_NUM_CHANNELS),
    .ChW   (CH_W)
  ) u_wr_arb (
    .clk_i         (M_AXI_ACLK),
    .rst_ni        (M_AXI_ARESETN),
    .req_i         (w_req),
    .done_i        (w_done),
    .active_ch_o   (w_active_channel),
    .grant_valid_o (w_grant_valid)
  );

endmodule

// File: tb/tb_channel_arbiter.sv
// Self-checking bench for channel_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_channel_arbiter;

  localparam int N = 4;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] r_req, w_req;
  logic         r_done, w_done;
  logic [W-1:0] r_ch, w_ch;
  logic         r_vld, w_vld;

  int vectors;
  int miscompares;

  channel_arbiter #(
    .C_M_NUM_CHANNELS (N)
  ) dut (
    .M_AXI_ACLK       (clk),
    .M_AXI_ARESETN    (rst_n),
    .r_req            (r_req),
    .r_done           (r_done),
    .w_req            (w_req),
    .w_done           (w_done),
    .r_active_channel (r_ch),
    .r_grant_valid    (r_vld),
    .w_active_channel (w_ch),
    .w_grant_valid    (w_vld)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: a side is either holding one grant or free; a free side takes the first
  // requester found walking upward from one past the previous grant.
  function automatic int pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return last;
  endfunction

  logic m_rv, m_wv;
  int   m_rc, m_wc, m_rl, m_wl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rv <= 1'b0; m_rc <= 0; m_rl <= N - 1;
      m_wv <= 1'b0; m_wc <= 0; m_wl <= N - 1;
    end else begin
      if (!m_rv) begin
        if (r_req != '0) begin
          m_rc <= pick(r_req, m_rl);
          m_rv <= 1'b1;
        end
      end else if (r_done) begin
        m_rv <= 1'b0;
        m_rl <= m_rc;
      end
      if (!m_wv) begin
        if (w_req != '0) begin
          m_wc <= pick(w_req, m_wl);
          m_wv <= 1'b1;
        end
      end else if (w_done) begin
        m_wv <= 1'b0;
        m_wl <= m_wc;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (r_vld !== 1'b0 || w_vld !== 1'b0 || r_ch !== 3'd0 || w_ch !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_held: rv=%b wv=%b rch=%0d wch=%0d required 0/0/0/0",
               r_vld, w_vld, r_ch, w_ch);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (r_vld !== 1'b0 || w_vld !== 1'b0 || r_ch !== 3'd0 || w_ch !== 3'd0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d: rv=%b wv=%b rch=%0d wch=%0d required 0/0/0/0",
                 c, r_vld, w_vld, r_ch, w_ch);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int waited;
    r_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (!r_vld && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      vectors++;
      if (r_vld !== 1'b1 || waited != 1 || r_ch !== 3'(exp_seq[g])) begin
        miscompares++;
        $display("FAIL rr_grant%0d: valid=%b ch=%0d wait=%0d required 1/%0d/1",
                 g, r_vld, r_ch, waited, exp_seq[g]);
      end
      repeat (2) @(negedge clk);
      if (g == 4) r_req = '0;
      r_done = 1'b1;
      @(negedge clk);
      r_done = 1'b0;
      vectors++;
      if (r_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_gap%0d: valid=%b required 0", g, r_vld);
      end
    end
  endtask

  task automatic test_skip();
    int exp_seq[3] = '{1, 3, 1};
    int waited;
    w_req = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      waited = 0;
      while (!w_vld && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      vectors++;
      if (w_vld !== 1'b1 || w_ch !== 3'(exp_seq[g])) begin
        miscompares++;
        $display("FAIL skip_grant%0d: valid=%b ch=%0d required 1/%0d",
                 g, w_vld, w_ch, exp_seq[g]);
      end
      @(negedge clk);
      if (g == 2) w_req = '0;
      w_done = 1'b1;
      @(negedge clk);
      w_done = 1'b0;
    end
  endtask

  task automatic test_independence();
    r_req = 4'b0100;
    w_req = 4'b0100;
    @(negedge clk);
    vectors++;
    if (r_vld !== 1'b1 || w_vld !== 1'b1 || r_ch !== 3'd2 || w_ch !== 3'd2) begin
      miscompares++;
      $display("FAIL indep_both: rv=%b wv=%b rch=%0d wch=%0d required 1/1/2/2",
               r_vld, w_vld, r_ch, w_ch);
    end
    r_req = '0;
    w_req = '0;
    w_done = 1'b1;
    @(negedge clk);
    w_done = 1'b0;
    vectors++;
    if (w_vld !== 1'b0 || r_vld !== 1'b1 || r_ch !== 3'd2) begin
      miscompares++;
      $display("FAIL indep_wdone: wv=%b rv=%b rch=%0d required 0/1/2", w_vld, r_vld, r_ch);
    end
    r_done = 1'b1;
    @(negedge clk);
    r_done = 1'b0;
    vectors++;
    if (r_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL indep_rdone: rv=%b required 0", r_vld);
    end
  endtask

  task automatic test_hold();
    r_done = 1'b1;
    @(negedge clk);
    r_done = 1'b0;
    vectors++;
    if (r_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_idle_done: rv=%b required 0", r_vld);
    end
    r_req = 4'b0010;
    @(negedge clk);
    vectors++;
    if (r_vld !== 1'b1 || r_ch !== 3'd1) begin
      miscompares++;
      $display("FAIL hold_grant: rv=%b rch=%0d required 1/1", r_vld, r_ch);
    end
    r_req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (r_vld !== 1'b1 || r_ch !== 3'd1) begin
        miscompares++;
        $display("FAIL hold_busy cyc%0d: rv=%b rch=%0d required 1/1", c, r_vld, r_ch);
      end
    end
    r_done = 1'b1;
    @(negedge clk);
    r_done = 1'b0;
    vectors++;
    if (r_vld !== 1'b0 || r_ch !== 3'd1) begin
      miscompares++;
      $display("FAIL hold_release: rv=%b rch=%0d required 0/1", r_vld, r_ch);
    end
  endtask

  task automatic test_mid_reset();
    r_req = 4'b1000;
    @(negedge clk);
    vectors++;
    if (r_vld !== 1'b1 || r_ch !== 3'd3) begin
      miscompares++;
      $display("FAIL midrst_grant: rv=%b rch=%0d required 1/3", r_vld, r_ch);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (r_vld !== 1'b0 || r_ch !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_async: rv=%b rch=%0d required 0/0", r_vld, r_ch);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (r_vld !== 1'b1 || r_ch !== 3'd3) begin
      miscompares++;
      $display("FAIL midrst_regrant: rv=%b rch=%0d required 1/3", r_vld, r_ch);
    end
    r_req = '0;
    r_done = 1'b1;
    @(negedge clk);
    r_done = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      vectors++;
      if (r_vld !== m_rv || (m_rv && r_ch !== 3'(m_rc)) || w_vld !== m_wv ||
          (m_wv && w_ch !== 3'(m_wc))) begin
        miscompares++;
        $display("FAIL random cyc%0d: r=%b/%0d w=%b/%0d required r=%b/%0d w=%b/%0d",
                 c, r_vld, r_ch, w_vld, w_ch, m_rv, m_rc, m_wv, m_wc);
      end
      vectors++;
      if (r_ch[W-1] !== 1'b0 || w_ch[W-1] !== 1'b0) begin
        miscompares++;
        $display("FAIL random_msb cyc%0d: rch=%0d wch=%0d required msb 0", c, r_ch, w_ch);
      end
      r_req  = N'($urandom);
      w_req  = N'($urandom);
      r_done = ($urandom_range(0, 3) == 0);
      w_done = ($urandom_range(0, 3) == 0);
    end
    r_req  = '0;
    w_req  = '0;
    r_done = 1'b0;
    w_done = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    r_req  = '0;
    w_req  = '0;
    r_done = 1'b0;
    w_done = 1'b0;
    test_reset();
    test_round_robin();
    test_skip();
    test_independence();
    test_hold();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/channel_arbiter.md
CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 The block SHALL have parameter C_M_NUM_CHANNELS, default 4, giving the number of DMA channels (1..32).
REQ-002 The block SHALL have parameter CH_W, default C_LOG_2(C_M_NUM_CHANNELS)+1, giving the channel index width.
REQ-003 The block SHALL have M_AXI_ACLK  input  1  as its single clock; all logic is rising-edge.
REQ-004 The block SHALL have M_AXI_ARESETN  input  1  as its reset: asynchronous, active-low.
REQ-005 The block SHALL have r_req  input  C_M_NUM_CHANNELS  meaning per-channel pending memory-read (fills channel FIFO).
REQ-006 The block SHALL have r_done  input  1  meaning a single-cycle pulse from the AXI read engine when the granted transfer completes.
REQ-007 The block SHALL have w_req  input  C_M_NUM_CHANNELS  meaning per-channel pending memory-write (drains channel FIFO).
REQ-008 The block SHALL have w_done  input  1  meaning a single-cycle pulse from the AXI write engine when the granted transfer completes.
REQ-009 The block SHALL have r_active_channel  output  CH_W  meaning the granted read-side channel index, driving the FIFO-full/wr_ack mux select.
REQ-010 The block SHALL have r_grant_valid  output  1  meaning the r_active_channel grant is live.
REQ-011 The block SHALL have w_active_channel  output  CH_W  meaning the granted write-side channel index, driving the FIFO-empty/rd_ack/rd_data mux select.
REQ-012 The block SHALL have w_grant_valid  output  1  meaning the w_active_channel grant is live.

Function
REQ-013 The read and write sides SHALL arbitrate independently and identically; the rules below apply per side.
REQ-014 Each side SHALL be a two-state FSM: IDLE and BUSY.
REQ-015 In IDLE with any req bit set, the side SHALL pick a winner round-robin, starting at (last_grant+1) mod C_M_NUM_CHANNELS and wrapping.
REQ-016 On the clock edge after that request cycle, the side SHALL register the winner on *_active_channel, assert *_grant_valid and enter BUSY (1-cycle grant latency).
REQ-017 In BUSY, the side SHALL hold the grant and index stable, ignoring req changes including deassertion of the granted channel's req.
REQ-018 A done pulse in BUSY SHALL deassert *_grant_valid, set last_grant to the granted index and return to IDLE on the next edge.
REQ-019 This gives a minimum 1-cycle gap between consecutive grants on a side.
REQ-020 A done pulse in IDLE SHALL be ignored.
REQ-021 In IDLE, *_active_channel SHALL hold its last value so the downstream mux always sees a legal index.
REQ-022 The MSB of *_active_channel SHALL always be 0, and the index SHALL never exceed C_M_NUM_CHANNELS-1.
REQ-023 Simultaneous read and write activity on the same channel SHALL be permitted; the sides do not interlock.
REQ-024 When C_M_NUM_CHANNELS=1, any req SHALL grant channel 0; the round-robin degenerates to a single channel.

Reset
REQ-025 While M_AXI_ARESETN is low, both FSMs SHALL be IDLE, *_grant_valid SHALL be 0, *_active_channel SHALL be 0, and last_grant SHALL be C_M_NUM_CHANNELS-1, so the first grant searches from channel 0.
REQ-026 Reset asserted mid-BUSY SHALL drop the grant immediately (asynchronously), with no done required.
REQ-027 After reset release, the first edge with a req present SHALL grant per REQ-015.

Structure
REQ-028 C_LOG_2 and the arbiter state enum (IDLE, BUSY) SHALL live in the shared package dma_pkg.
REQ-029 One sub-module rr_arbiter (FSM, pointer, priority search) SHALL be instantiated twice, once per side.

Verification
REQ-030 Reset scenario: apply reset, then release with no req -> valid=0 and both indices=0 for 10 cycles.
REQ-031 Round-robin scenario: N=4, r_req=4'b1111 held, r_done 3 cycles after each grant -> r_active_channel sequence 0,1,2,3,0 with a 1-cycle valid-low gap between grants.
REQ-032 Skip scenario: w_req=4'b1010 held -> grants 1,3,1; channel 0 and 2 are never granted.
REQ-033 Independence scenario: r_req=4'b0100 with w_req=4'b0100 at the same cycle -> both sides grant channel 2 the next cycle; w_done alone releases only the write side.
REQ-034 Hold scenario: grant channel 1, then deassert r_req[1] and pulse r_done while IDLE beforehand -> grant remains 1 until r_done in BUSY; the IDLE-time done is ignored.
REQ-035 Mid-BUSY reset scenario: assert reset while BUSY on channel 3 -> valid drops without waiting for a clock edge; after release with r_req=4'b1000, channel 3 is granted again.
